// File: rtl/imem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : imem_arbiter
//  Purpose  : Shares one single-port, synchronous-read instruction memory
//             between the core fetch port and the program loader write port.
//             The core is held off during the boot phase until the loader
//             reports the image complete. After boot, the two requesters are
//             served round-robin.
//             Every transaction is IDLE -> ACCESS -> RESP (3 cycles).
//  Options  : IMEM_ARB_ERR_EN - adds core_err_o, which flags core accesses
//             that are out of range or misaligned.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
  parameter int MEM_WORDS = 4096,
  parameter int MEM_AW    = $clog2(MEM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // core fetch port
  input  logic              core_req_i,
  input  logic [31:0]       core_addr_i,
  output logic [31:0]       core_rdata_o,
  output logic              core_rvalid_o,
  output logic              core_stall_o,
  // program loader port
  input  logic              ldr_req_i,
  input  logic [31:0]       ldr_addr_i,
  input  logic [31:0]       ldr_wdata_i,
  input  logic              ldr_done_i,
  output logic              ldr_ack_o,
  // memory macro port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
`ifdef IMEM_ARB_ERR_EN
  ,
  output logic              core_err_o
`endif
);

  // FSM encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // requester identifiers, used for both the grant ID and last_grant
  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_LDR  = 1'b1;

  // Word-index slice and the shift that isolates the out-of-range bits
  localparam int ADDR_HI   = MEM_AW + 1;
  localparam int OOR_SHIFT = MEM_AW + 2;

  logic [1:0]  state_q, state_d;
  logic        boot_q, boot_d;
  logic        last_q, last_d;
  logic        id_q;
  logic        inrange_q;

  logic        core_elig;
  logic        grant_vld;
  logic        grant_ldr;
  logic [31:0] sel_addr;
  logic        sel_inrange;

  // Pick the winner for this IDLE cycle and classify its address
  always_comb begin
    core_elig = core_req_i & ~boot_q;
    grant_vld = (state_q == S_IDLE) & (core_elig | ldr_req_i);
    if (ldr_req_i && core_elig) begin
      // Both requesting: the one that was not granted last time wins
      grant_ldr = (last_q == GNT_CORE);
    end else begin
      grant_ldr = ldr_req_i;
    end
    sel_addr    = grant_ldr ? ldr_addr_i : core_addr_i;
    sel_inrange = ((sel_addr >> OOR_SHIFT) == 32'd0);
  end

  // Next-state logic for the FSM, boot flag and round-robin pointer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_vld) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Boot ends on any ldr_done_i edge and never re-arms outside reset
    boot_d = ldr_done_i ? 1'b0 : boot_q;
    last_d = grant_vld ? grant_ldr : last_q;
  end

  // Control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      boot_q  <= 1'b1;
      last_q  <= GNT_CORE;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      last_q  <= last_d;
    end
  end

  // Latch the granted requester ID and address class for the response phase
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q      <= GNT_CORE;
      inrange_q <= 1'b0;
    end else if (grant_vld) begin
      id_q      <= grant_ldr;
      inrange_q <= sel_inrange;
    end
  end

  // Memory strobe is registered at grant time. Out-of-range accesses never
  // strobe, and address, we and data keep their previous values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'd0;
    end else begin
      mem_req_o <= grant_vld & sel_inrange;
      if (grant_vld && sel_inrange) begin
        mem_we_o   <= grant_ldr;
        mem_addr_o <= sel_addr[ADDR_HI:2];
        if (grant_ldr) begin
          mem_wdata_o <= ldr_wdata_i;
        end
      end
    end
  end

  // Response pulses: issued on the edge that closes ACCESS, and captured
  // together with the memory read data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_rdata_o  <= 32'd0;
      core_rvalid_o <= 1'b0;
      ldr_ack_o     <= 1'b0;
    end else begin
      core_rvalid_o <= 1'b0;
      ldr_ack_o     <= 1'b0;
      if (state_q == S_ACCESS) begin
        if (id_q == GNT_CORE) begin
          core_rvalid_o <= 1'b1;
          core_rdata_o  <= inrange_q ? mem_rdata_i : 32'd0;
        end else begin
          ldr_ack_o <= 1'b1;
        end
      end
    end
  end

  // The core must hold its PC while booting or while a fetch is outstanding
  assign core_stall_o = boot_q | (core_req_i & ~core_rvalid_o);

`ifdef IMEM_ARB_ERR_EN
  logic misalign_q;

  // Remember whether the granted address had nonzero byte-offset bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (grant_vld) begin
      misalign_q <= |sel_addr[1:0];
    end
  end

  // Error flag pulses alongside rvalid for bad core accesses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_err_o <= 1'b0;
    end else begin
      core_err_o <= (state_q == S_ACCESS) && (id_q == GNT_CORE) &&
                    (!inrange_q || misalign_q);
    end
  end
`else
  // Byte-offset bits have no effect without the error flag
  logic unused_lsb;
  assign unused_lsb = ^sel_addr[1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_imem_arbiter
//  Purpose  : Self-checking bench for imem_arbiter. It runs directed vector
//             tables, hand-written corner sequences, and random traffic
//             against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

  localparam int          MEM_WORDS = 4096;
  localparam int          MEM_AW    = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              core_req = 1'b0;
  logic [31:0]       core_addr = 32'd0;
  logic [31:0]       core_rdata;
  logic              core_rvalid;
  logic              core_stall;
  logic              ldr_req = 1'b0;
  logic [31:0]       ldr_addr = 32'd0;
  logic [31:0]       ldr_wdata = 32'd0;
  logic              ldr_done = 1'b0;
  logic              ldr_ack;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
`ifdef IMEM_ARB_ERR_EN
  logic              core_err;
`endif

  imem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_req_i   (core_req),
    .core_addr_i  (core_addr),
    .core_rdata_o (core_rdata),
    .core_rvalid_o(core_rvalid),
    .core_stall_o (core_stall),
    .ldr_req_i    (ldr_req),
    .ldr_addr_i   (ldr_addr),
    .ldr_wdata_i  (ldr_wdata),
    .ldr_done_i   (ldr_done),
    .ldr_ack_o    (ldr_ack),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
`ifdef IMEM_ARB_ERR_EN
    ,
    .core_err_o   (core_err)
`endif
  );

  always #5 clk = ~clk;

  // Memory macro stand-in: read data is valid at the edge closing the strobe.
  // Data with no strobe reads as junk, so leaked reads cannot pass as zero.
  logic [31:0] mem [MEM_WORDS];
  logic        mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'd0;
    end else if (mem_req && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_req && !mem_we) ? mem[mem_addr] : 32'hDEAD_BEEF;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        is_ldr;
    logic        done;    // pulse ldr_done_i for one idle cycle first
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mreq;
    logic [31:0] maddr;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt[12];
  logic tb_boot;

  // One complete transaction from an idle arbiter, with fixed-latency checks
  task automatic run_txn(input vec_t v);
    if (v.done) begin
      ldr_done = 1'b1;
      tick();
      ldr_done = 1'b0;
      tb_boot  = 1'b0;
    end
    if (v.is_ldr) begin
      ldr_req = 1'b1; ldr_addr = v.addr; ldr_wdata = v.wdata;
    end else begin
      core_req = 1'b1; core_addr = v.addr;
    end
    tick();  // grant edge
    check("vec_mem_req", 32'(mem_req), 32'(v.mreq));
    if (v.mreq) begin
      check("vec_mem_we", 32'(mem_we), 32'(v.is_ldr));
      check("vec_mem_addr", 32'(mem_addr), v.maddr);
      if (v.is_ldr) check("vec_mem_wdata", mem_wdata, v.wdata);
    end
    check("vec_resp_early", 32'(core_rvalid | ldr_ack), 32'd0);
    check("vec_stall_wait", 32'(core_stall), 32'(tb_boot | !v.is_ldr));
    tick();  // response edge
    check("vec_rvalid", 32'(core_rvalid), 32'(!v.is_ldr));
    check("vec_ack", 32'(ldr_ack), 32'(v.is_ldr));
    check("vec_stall_resp", 32'(core_stall), 32'(tb_boot));
    check("vec_mem_req_off", 32'(mem_req), 32'd0);
    if (!v.is_ldr) begin
      check("vec_rdata", core_rdata, v.rdata);
`ifdef IMEM_ARB_ERR_EN
      check("vec_err", 32'(core_err), 32'(v.err));
`endif
    end
    core_req = 1'b0; ldr_req = 1'b0;
    tick();  // back to idle
    check("vec_resp_done", 32'(core_rvalid | ldr_ack), 32'd0);
  endtask

  // ------------------------------------------------------- reference model
  logic [31:0] ref_mem [MEM_WORDS];
  logic        mboot, last_core, have;
  int          next_free, t_grant;
  logic        t_ldr, t_inr, t_err;
  logic [31:0] t_addr, t_wdata, t_data;

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 99);
    if (r < 10)      return 32'h4000 + 32'($urandom_range(0, 255) << 2);
    else if (r < 13) return 32'hFFFF_FFFC;
    else if (r < 18) return 32'h3FFC;
    else if (r < 30) return {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
    else             return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  initial begin
    logic e_mreq, e_resp, pick_ldr, core_ok;

    vt[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0050_0093, 1'b1, 32'd0,     32'd0,         1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0010_0113, 1'b1, 32'd1,     32'd0,         1'b0};
    vt[2]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0020_81B3, 1'b1, 32'd2,     32'd0,         1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h1234_5678, 1'b0, 32'd0,     32'd0,         1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'h0000_0004, 32'd0,         1'b1, 32'd1,     32'h0010_0113, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h0000_0000, 32'd0,         1'b1, 32'd0,     32'h0050_0093, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 32'h0000_0008, 32'd0,         1'b1, 32'd2,     32'h0020_81B3, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 32'h0000_4000, 32'd0,         1'b0, 32'd0,     32'd0,         1'b1};
    vt[8]  = '{1'b0, 1'b0, 32'h0000_0006, 32'd0,         1'b1, 32'd1,     32'h0010_0113, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 32'h0000_3FFC, 32'd0,         1'b1, 32'hFFF,   32'd0,         1'b0};
    vt[10] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'hCAFE_F00D, 1'b1, 32'hFFF,   32'd0,         1'b0};
    vt[11] = '{1'b0, 1'b0, 32'h0000_3FFC, 32'd0,         1'b1, 32'hFFF,   32'hCAFE_F00D, 1'b0};

    // ---- reset values
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    check("rst_rvalid", 32'(core_rvalid), 32'd0);
    check("rst_ack", 32'(ldr_ack), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    check("rst_stall", 32'(core_stall), 32'd1);
    rst = 1'b0;
    tb_boot = 1'b1;

    // ---- boot phase blocks the core completely
    core_req = 1'b1; core_addr = 32'h0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("boot_stall", 32'(core_stall), 32'd1);
      check("boot_mem_req", 32'(mem_req), 32'd0);
      check("boot_rvalid", 32'(core_rvalid), 32'd0);
    end
    core_req = 1'b0;
    tick();

    // ---- directed vector table: load, end boot, fetch, boundaries
    for (int i = 0; i < 12; i++) run_txn(vt[i]);

    // ---- contention: last grant was the core, so the loader goes first
    ldr_req = 1'b1; ldr_addr = 32'h10; ldr_wdata = 32'hA5A5_0001;
    core_req = 1'b1; core_addr = 32'h10;
    for (int t = 0; t < 12; t++) begin
      tick();
      check("rr_mem_req", 32'(mem_req), 32'(t % 3 == 0));
      if (t % 3 == 0) check("rr_grant_we", 32'(mem_we), 32'(t % 6 == 0));
      check("rr_ack", 32'(ldr_ack), 32'(t % 6 == 1));
      check("rr_rvalid", 32'(core_rvalid), 32'(t % 6 == 4));
      if (t == 4)  check("rr_rdata1", core_rdata, 32'hA5A5_0001);
      if (t == 10) check("rr_rdata2", core_rdata, 32'hA5A5_0002);
      if (t == 1)  ldr_wdata = 32'hA5A5_0002;
      if (t == 7)  ldr_wdata = 32'hA5A5_0003;
    end
    ldr_req = 1'b0; core_req = 1'b0;
    tick();

    // ---- asynchronous reset in the middle of ACCESS
    core_req = 1'b1; core_addr = 32'h8;
    tick();
    check("ar_mem_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_mem_req", 32'(mem_req), 32'd0);
    check("ar_mem_addr", 32'(mem_addr), 32'd0);
    check("ar_rdata", core_rdata, 32'd0);
    check("ar_rvalid", 32'(core_rvalid), 32'd0);
    check("ar_stall", 32'(core_stall), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ar_no_rvalid", 32'(core_rvalid), 32'd0);
      check("ar_no_mem_req", 32'(mem_req), 32'd0);
      check("ar_boot_stall", 32'(core_stall), 32'd1);
    end
    core_req = 1'b0;

    // ---- randomized traffic against the transaction-level model
    rst = 1'b1; mem_clr = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'd0;
    tick();
    rst = 1'b0; mem_clr = 1'b0;
    mboot = 1'b1; last_core = 1'b1; have = 1'b0; next_free = 0; t_grant = 0;
    t_ldr = 1'b0; t_inr = 1'b0; t_err = 1'b0; t_addr = 0; t_wdata = 0; t_data = 0;
    for (int k = 0; k < 3000; k++) begin
      core_ok = core_req && !mboot;
      if (k >= next_free && (ldr_req || core_ok)) begin
        pick_ldr  = ldr_req && (!core_ok || last_core);
        t_ldr     = pick_ldr;
        t_grant   = k;
        t_addr    = pick_ldr ? ldr_addr : core_addr;
        t_wdata   = ldr_wdata;
        t_inr     = t_addr < MEM_BYTES;
        t_err     = !t_inr || (t_addr[1:0] != 2'b00);
        t_data    = t_inr ? ref_mem[t_addr[MEM_AW+1:2]] : 32'd0;
        if (pick_ldr && t_inr) ref_mem[t_addr[MEM_AW+1:2]] = ldr_wdata;
        last_core = !pick_ldr;
        next_free = k + 3;
        have      = 1'b1;
      end
      if (ldr_done) mboot = 1'b0;
      tick();
      e_mreq = have && (k == t_grant) && t_inr;
      e_resp = have && (k == t_grant + 1);
      check("rnd_mem_req", 32'(mem_req), 32'(e_mreq));
      if (e_mreq) begin
        check("rnd_mem_we", 32'(mem_we), 32'(t_ldr));
        check("rnd_mem_addr", 32'(mem_addr), 32'(t_addr[MEM_AW+1:2]));
        if (t_ldr) check("rnd_mem_wdata", mem_wdata, t_wdata);
      end
      check("rnd_rvalid", 32'(core_rvalid), 32'(e_resp && !t_ldr));
      check("rnd_ack", 32'(ldr_ack), 32'(e_resp && t_ldr));
      if (e_resp && !t_ldr) check("rnd_rdata", core_rdata, t_data);
`ifdef IMEM_ARB_ERR_EN
      check("rnd_err", 32'(core_err), 32'(e_resp && !t_ldr && t_err));
`endif
      check("rnd_stall", 32'(core_stall), 32'(mboot | (core_req & !(e_resp && !t_ldr))));

      // requester behaviour for the next edge
      ldr_done = (k > 300) && ($urandom_range(0, 99) == 0);
      if (core_req) begin
        if (e_resp && !t_ldr) begin
          if ($urandom_range(0, 3) == 0) core_addr = rand_addr();
          else core_req = 1'b0;
        end
      end else if ($urandom_range(0, 9) < 3) begin
        core_req = 1'b1; core_addr = rand_addr();
      end
      if (ldr_req) begin
        if (e_resp && t_ldr) begin
          if ($urandom_range(0, 3) == 0) begin
            ldr_addr = rand_addr(); ldr_wdata = $urandom();
          end else begin
            ldr_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 9) < 3) begin
        ldr_req = 1'b1; ldr_addr = rand_addr(); ldr_wdata = $urandom();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, synchronous-read, word-wide instruction memory between two requesters: the core fetch port and the program loader write port.
- Holds the core in a boot phase until the loader signals that the program image is complete.
- After boot, arbitrates round-robin between the two requesters.
- Sits between the fetch stage/loader and the instruction memory macro.

Parameters:
MEM_WORDS, 4096, memory depth in 32-bit words (power of 2); byte address space is MEM_WORDS*4
MEM_AW, $clog2(MEM_WORDS), word-index width driven to memory

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
core_req_i  in  1  fetch request, held until core_rvalid_o
core_addr_i  in  32  fetch byte address
core_rdata_o  out  32  fetched instruction word
core_rvalid_o  out  1  one-cycle pulse, core_rdata_o valid
core_stall_o  out  1  core must hold PC
ldr_req_i  in  1  loader write request, held until ldr_ack_o
ldr_addr_i  in  32  loader byte address
ldr_wdata_i  in  32  loader write data
ldr_done_i  in  1  loader finished, ends boot phase
ldr_ack_o  out  1  one-cycle pulse, write accepted/completed
mem_req_o  out  1  memory access strobe
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  MEM_AW  word index = addr[MEM_AW+1:2]
mem_wdata_o  out  32  write data
mem_rdata_i  in  32  read data, valid on the clock edge closing the mem_req_o cycle

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE, boot_q=1, last_grant=CORE. core_rdata_o=0, core_rvalid_o=0, ldr_ack_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0. An in-flight transaction is dropped; no ack or rvalid is issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: select a requester; if one is granted, latch its address, data and ID, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: exactly one cycle. Drive mem_req_o=1 (registered outputs) and mem_we_o=1 for a loader grant. Then go to RESP.
- RESP: exactly one cycle.
  - Core grant: core_rdata_o <= mem_rdata_i, core_rvalid_o=1.
  - Loader grant: ldr_ack_o=1.
  - Then go to IDLE.
- Latency: request seen high at edge N in IDLE → ACCESS during N..N+1 → rvalid/ack high during N+1..N+2. Each transaction takes 3 cycles. Max throughput: one access per 3 cycles.
- Requesters must hold req and address stable until their response. The sampled values are latched at grant, so changes after grant are ignored. A requester whose req is still high in IDLE after its response is treated as a new request.
- Arbitration in IDLE:
  - boot_q=1: only the loader is eligible; the core is never granted.
  - boot_q=0, one requester: grant it.
  - boot_q=0, both requesting: grant the one that is not last_grant. last_grant updates on every grant.
- Boot: boot_q clears on any edge where ldr_done_i=1, in any state. A loader transaction in flight completes normally. boot_q never sets again except through reset.
- core_stall_o = boot_q | (core_req_i & ~core_rvalid_o), combinational.
- Out-of-range address (byte addr ≥ MEM_WORDS*4):
  - The FSM still runs ACCESS and RESP with the same latency, but mem_req_o stays 0.
  - Core read: core_rdata_o=0 with rvalid.
  - Loader write: dropped, ldr_ack_o still pulses.
- addr[1:0] is ignored; all accesses are word-aligned.
- mem_addr_o, mem_we_o and mem_wdata_o hold their last values when mem_req_o=0.

Optional Feature:
- Macro: IMEM_ARB_ERR_EN.
- Defined:
  - Adds output port core_err_o (1 bit), reset 0.
  - core_err_o pulses together with core_rvalid_o when the core access was out of range or addr[1:0]≠0.
  - A misaligned in-range access still reads the aligned word.
- Undefined: the port is absent, and out-of-range/misaligned accesses are silent (zero data / aligned read).

Test Plan:
- Reset and boot block: rst_i pulse, then core_req_i=1 addr 0x0 with no loader activity for 20 cycles → core_stall_o=1 throughout, mem_req_o=0, core_rvalid_o=0.
- Load then fetch: loader writes 0x00500093@0x0, 0x00100113@0x4, 0x002081B3@0x8, each acked 2 cycles after grant, then ldr_done_i. Core reads 0x4 → mem_addr_o=1 in ACCESS, core_rdata_o=0x00100113 with rvalid exactly 2 cycles after grant.
- Contention after boot: core and loader both requesting continuously with last_grant=CORE → grant order loader, core, loader, core. No requester is starved, one access per 3 cycles.
- Out of range: core reads 0x4000 with MEM_WORDS=4096 → mem_req_o stays 0, core_rdata_o=0, rvalid on schedule. A loader write to 0x4000 is acked, and memory is unchanged.
- Async reset during ACCESS: rst_i asserted mid-cycle → all outputs 0 immediately, no rvalid/ack for the aborted access, boot_q=1 again.
- With IMEM_ARB_ERR_EN defined: core reads 0x6 → aligned word at 0x4 returned, core_err_o=1 coincident with rvalid. An aligned in-range read gives core_err_o=0.
